// File: rtl/dmem_lockstep_responder.sv
// Lockstep data-memory responder: grants twin-core requests only when they agree.
// Optional wait-timeout counter enabled by DMEM_LOCKSTEP_TIMEOUT_EN.
module dmem_lockstep_responder #(
    parameter logic [31:0] FLAG_ADDR   = 32'h0000_1000,
    parameter logic [31:0] RESULT_ADDR = 32'h0000_1004,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        a_req_i,
    input  logic        b_req_i,
    input  logic        a_we_i,
    input  logic        b_we_i,
    input  logic [31:0] a_addr_i,
    input  logic [31:0] b_addr_i,
    input  logic [31:0] a_wdata_i,
    input  logic [31:0] b_wdata_i,
    input  logic [3:0]  a_be_i,
    input  logic [3:0]  b_be_i,
    output logic        a_gnt_o,
    output logic        b_gnt_o,
    output logic        a_rvalid_o,
    output logic        b_rvalid_o,
    output logic [31:0] a_rdata_o,
    output logic [31:0] b_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic [31:0] mem_rdata_i,
    output logic        mismatch_o,
    output logic        timeout_o,
    output logic        flag_o,
    output logic [31:0] result_o
);

    typedef enum logic [1:0] {IDLE, WAIT_A, WAIT_B, ERROR} state_e;

    state_e      state_q, state_d;
    logic        rvalid_q;
    logic        mismatch_q;
    logic        flag_q;
    logic [31:0] result_q;
    logic        both_req;
    logic        req_match;
    logic        grant;
    logic        mis_set;

    assign both_req  = a_req_i & b_req_i;
    assign req_match = (a_we_i == b_we_i) && (a_addr_i == b_addr_i) && (a_be_i == b_be_i)
                       && (!a_we_i || (a_wdata_i == b_wdata_i));
    assign grant     = rst_ni && (state_q != ERROR) && both_req && req_match;

`ifdef DMEM_LOCKSTEP_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q;
    logic          to_set;
    logic          in_wait;

    assign in_wait = (state_q == WAIT_A) || (state_q == WAIT_B);
    // Counter only runs while the same core keeps waiting; any state change restarts it.
    assign cnt_d   = (in_wait && (state_d == state_q)) ? cnt_q + 1'b1 : '0;
`endif

    always_comb begin
        state_d = state_q;
        mis_set = 1'b0;
`ifdef DMEM_LOCKSTEP_TIMEOUT_EN
        to_set  = 1'b0;
`endif
        if (state_q != ERROR) begin
            if (both_req) begin
                state_d = req_match ? IDLE : ERROR;
                mis_set = !req_match;
            end else if (a_req_i || b_req_i) begin
`ifdef DMEM_LOCKSTEP_TIMEOUT_EN
                // A twin arriving at the limit is handled above, so it wins over the timeout.
                if (in_wait && (cnt_q == CW'(TIMEOUT - 1))) begin
                    state_d = ERROR;
                    to_set  = 1'b1;
                end else
`endif
                state_d = a_req_i ? WAIT_A : WAIT_B;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rvalid_q   <= 1'b0;
            mismatch_q <= 1'b0;
            flag_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= grant;
            if (mis_set) begin
                mismatch_q <= 1'b1;
            end
            if (grant && a_we_i && (a_addr_i == FLAG_ADDR)) begin
                flag_q <= 1'b1;
            end
            if (grant && a_we_i && (a_addr_i == RESULT_ADDR)) begin
                result_q <= a_wdata_i;
            end
        end
    end

`ifdef DMEM_LOCKSTEP_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (to_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign a_gnt_o     = grant;
    assign b_gnt_o     = grant;
    assign mem_req_o   = grant;
    assign mem_we_o    = rst_ni & a_we_i;
    assign mem_addr_o  = rst_ni ? a_addr_i  : '0;
    assign mem_wdata_o = rst_ni ? a_wdata_i : '0;
    assign mem_be_o    = rst_ni ? a_be_i    : '0;

    assign a_rvalid_o  = rvalid_q;
    assign b_rvalid_o  = rvalid_q;
    assign a_rdata_o   = rvalid_q ? mem_rdata_i : '0;
    assign b_rdata_o   = rvalid_q ? mem_rdata_i : '0;

    assign mismatch_o  = mismatch_q;
    assign flag_o      = flag_q;
    assign result_o    = result_q;

endmodule

// File: tb/tb_dmem_lockstep_responder.sv
// Directed bench for dmem_lockstep_responder with a behavioural reference model and SRAM.
// Follows DMEM_LOCKSTEP_TIMEOUT_EN to pick the timeout or no-timeout scenario.
module tb_dmem_lockstep_responder;

    localparam int unsigned TO = 16;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } rq_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    rq_t         ra = '0;
    rq_t         rb = '0;
    logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [31:0] a_rdata, b_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = '0;
    logic        mismatch, timeout, flag;
    logic [31:0] result;

    always #5 clk = ~clk;

    dmem_lockstep_responder #(
        .FLAG_ADDR  (32'h0000_1000),
        .RESULT_ADDR(32'h0000_1004),
        .TIMEOUT    (TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .a_req_i(ra.req), .b_req_i(rb.req),
        .a_we_i(ra.we), .b_we_i(rb.we),
        .a_addr_i(ra.addr), .b_addr_i(rb.addr),
        .a_wdata_i(ra.wdata), .b_wdata_i(rb.wdata),
        .a_be_i(ra.be), .b_be_i(rb.be),
        .a_gnt_o(a_gnt), .b_gnt_o(b_gnt),
        .a_rvalid_o(a_rvalid), .b_rvalid_o(b_rvalid),
        .a_rdata_o(a_rdata), .b_rdata_o(b_rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata),
        .mismatch_o(mismatch), .timeout_o(timeout), .flag_o(flag), .result_o(result)
    );

    // Environment SRAM: read-first, 1-cycle latency, byte-enabled writes.
    logic [31:0] sram [0:4095];
    always @(posedge clk) begin
        if (mem_req) begin
            mem_rdata <= sram[mem_addr[13:2]];
            if (mem_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (mem_be[i]) sram[mem_addr[13:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a memory image plus the few sticky facts the block exposes.
    logic [31:0] mdl [logic [31:0]];
    bit          m_err, m_mis, m_to, m_flag, m_rv;
    logic [31:0] m_res, m_rd;
    int          lone;
    bit          cmp_en = 0;

    function automatic bit same(input rq_t a, input rq_t b);
        return a.we == b.we && a.addr == b.addr && a.be == b.be && (!a.we || a.wdata == b.wdata);
    endfunction

    function automatic logic [31:0] mread(input logic [31:0] addr);
        return mdl.exists(addr[31:2]) ? mdl[addr[31:2]] : 32'h0;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        bit g;
        if (!rst_n) begin
            m_err = 0; m_mis = 0; m_to = 0; m_flag = 0; m_rv = 0;
            m_res = '0; m_rd = '0; lone = 0;
        end else begin
            g = !m_err && ra.req && rb.req && same(ra, rb);
            m_rv = g;
            if (g) begin
                lone = 0;
                m_rd = mread(ra.addr);
                if (ra.we) begin
                    mdl[ra.addr[31:2]] = merge(m_rd, ra.wdata, ra.be);
                    if (ra.addr == 32'h1000) m_flag = 1;
                    if (ra.addr == 32'h1004) m_res = ra.wdata;
                end
            end else if (!m_err && ra.req && rb.req) begin
                m_mis = 1;
                m_err = 1;
            end else if (!m_err && (ra.req ^ rb.req)) begin
                lone++;
`ifdef DMEM_LOCKSTEP_TIMEOUT_EN
                // First lone cycle is spent in IDLE; TO more cycles of waiting exhaust the budget.
                if (lone > TO) begin
                    m_to = 1;
                    m_err = 1;
                end
`endif
            end else begin
                lone = 0;
            end
        end
    end

    always @(negedge clk) begin
        bit eg;
        if (cmp_en) begin
            eg = rst_n && !m_err && ra.req && rb.req && same(ra, rb);
            chk("a_gnt", {31'b0, a_gnt}, {31'b0, eg});
            chk("b_gnt", {31'b0, b_gnt}, {31'b0, eg});
            chk("mem_req", {31'b0, mem_req}, {31'b0, eg});
            if (eg) begin
                chk("mem_we", {31'b0, mem_we}, {31'b0, ra.we});
                chk("mem_addr", mem_addr, ra.addr);
                chk("mem_be", {28'b0, mem_be}, {28'b0, ra.be});
                if (ra.we) chk("mem_wdata", mem_wdata, ra.wdata);
            end
            chk("a_rvalid", {31'b0, a_rvalid}, {31'b0, m_rv});
            chk("b_rvalid", {31'b0, b_rvalid}, {31'b0, m_rv});
            chk("a_rdata", a_rdata, m_rv ? m_rd : 32'h0);
            chk("b_rdata", b_rdata, m_rv ? m_rd : 32'h0);
            chk("mismatch", {31'b0, mismatch}, {31'b0, m_mis});
            chk("timeout", {31'b0, timeout}, {31'b0, m_to});
            chk("flag", {31'b0, flag}, {31'b0, m_flag});
            chk("result", result, m_res);
        end
    end

    function automatic rq_t rd(input logic [31:0] addr, input logic [31:0] junk = '0);
        return '{req: 1'b1, we: 1'b0, addr: addr, wdata: junk, be: 4'hF};
    endfunction

    function automatic rq_t wr(input logic [31:0] addr, input logic [31:0] d,
                               input logic [3:0] be = 4'hF);
        return '{req: 1'b1, we: 1'b1, addr: addr, wdata: d, be: be};
    endfunction

    task automatic setw(input logic [31:0] addr, input logic [31:0] v);
        sram[addr[13:2]] = v;
        mdl[addr[31:2]]  = v;
    endtask

    // Present a request pair for one cycle, checking the grant against a literal mid-cycle.
    task automatic issue(input rq_t a, input rq_t b, input logic exp_g, input string nm);
        ra = a;
        rb = b;
        #2;
        chk(nm, {31'b0, a_gnt}, {31'b0, exp_g});
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        ra = '0;
        rb = '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) sram[i] = '0;
        setw(32'h20, 32'h0000_0055);
        setw(32'h0, 32'h1111_1111);
        setw(32'h4, 32'h2222_2222);
        setw(32'h8, 32'h3333_3333);

        // Matched request during reset must stay ungranted.
        rst_n = 1'b0;
        ra = rd(32'h20);
        rb = rd(32'h20);
        @(posedge clk);
        #1;
        cmp_en = 1;
        chk("rst_gnt_low", {31'b0, a_gnt}, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_rvalid", {31'b0, a_rvalid}, 32'h0);
        chk("rst_rdata", a_rdata, 32'h0);
        chk("rst_result", result, 32'h0);
        chk("rst_flag", {31'b0, flag}, 32'h0);
        rst_n = 1'b1;
        idle_cycle();

        issue(rd(32'h20), rd(32'h20), 1'b1, "lit_rd20_gnt");
        chk("lit_rd20_rvalid", {31'b0, b_rvalid}, 32'h1);
        chk("lit_rd20_rdata", b_rdata, 32'h55);

        // Back-to-back reads: one response per cycle.
        issue(rd(32'h0), rd(32'h0), 1'b1, "lit_b2b0_gnt");
        chk("lit_b2b0", a_rdata, 32'h1111_1111);
        issue(rd(32'h4), rd(32'h4), 1'b1, "lit_b2b1_gnt");
        chk("lit_b2b1", a_rdata, 32'h2222_2222);
        issue(rd(32'h8), rd(32'h8), 1'b1, "lit_b2b2_gnt");
        chk("lit_b2b2", a_rdata, 32'h3333_3333);
        idle_cycle();
        chk("lit_b2b_end", {31'b0, a_rvalid}, 32'h0);

        // Reads match regardless of wdata; partial byte-enable write.
        issue(rd(32'h8, 32'h1), rd(32'h8, 32'h2), 1'b1, "lit_rd_wdata_ignored");
        issue(wr(32'h20, 32'hAABB_CCDD, 4'b0101), wr(32'h20, 32'hAABB_CCDD, 4'b0101), 1'b1, "lit_be_wr");
        issue(rd(32'h20), rd(32'h20), 1'b1, "lit_be_rd");
        chk("lit_be_data", a_rdata, 32'h00BB_00DD);
        idle_cycle();

        // A leads B by three cycles on a result write.
        issue(wr(32'h1004, 32'd7), '0, 1'b0, "lit_lag_n0");
        issue(wr(32'h1004, 32'd7), '0, 1'b0, "lit_lag_n1");
        issue(wr(32'h1004, 32'd7), '0, 1'b0, "lit_lag_n2");
        issue(wr(32'h1004, 32'd7), wr(32'h1004, 32'd7), 1'b1, "lit_lag_n3");
        chk("lit_result7", result, 32'd7);
        idle_cycle();

        // B leads A: same behaviour from the other side.
        issue('0, rd(32'h4), 1'b0, "lit_blead0");
        issue(rd(32'h4), rd(32'h4), 1'b1, "lit_blead1");
        idle_cycle();

        issue(wr(32'h1000, 32'd1), wr(32'h1000, 32'd1), 1'b1, "lit_flag_gnt");
        chk("lit_flag_set", {31'b0, flag}, 32'h1);
        idle_cycle();
        chk("lit_flag_sticky", {31'b0, flag}, 32'h1);
        rst_n = 1'b0;
        idle_cycle();
        rst_n = 1'b1;
        chk("lit_flag_clr", {31'b0, flag}, 32'h0);
        chk("lit_result_clr", result, 32'h0);
        chk("lit_mis_clr", {31'b0, mismatch}, 32'h0);
        issue(rd(32'h0), rd(32'h0), 1'b1, "lit_idle_after_rst");
        idle_cycle();

`ifdef DMEM_LOCKSTEP_TIMEOUT_EN
        // Twin arriving exactly at the limit is still granted.
        for (int i = 0; i < TO; i++) issue(rd(32'h8), '0, 1'b0, "lit_limit_wait");
        issue(rd(32'h8), rd(32'h8), 1'b1, "lit_limit_twin");
        idle_cycle();
        for (int i = 0; i < TO + 1; i++) issue(rd(32'h8), '0, 1'b0, "lit_to_wait");
        chk("lit_timeout", {31'b0, timeout}, 32'h1);
        issue(rd(32'h8), rd(32'h8), 1'b0, "lit_to_absorb");
`else
        for (int i = 0; i < 41; i++) issue(rd(32'h8), '0, 1'b0, "lit_long_wait");
        issue(rd(32'h8), rd(32'h8), 1'b1, "lit_long_twin");
        chk("lit_no_timeout", {31'b0, timeout}, 32'h0);
`endif
        rst_n = 1'b0;
        idle_cycle();
        rst_n = 1'b1;
        chk("lit_to_clr", {31'b0, timeout}, 32'h0);

        issue(wr(32'h40, 32'd5), wr(32'h40, 32'd6), 1'b0, "lit_mis_gnt");
        chk("lit_mis_set", {31'b0, mismatch}, 32'h1);
        issue(rd(32'h40), rd(32'h40), 1'b0, "lit_err_absorb0");
        issue(rd(32'h0), rd(32'h0), 1'b0, "lit_err_absorb1");
        rst_n = 1'b0;
        idle_cycle();
        rst_n = 1'b1;
        issue(rd(32'h0), rd(32'h4), 1'b0, "lit_addr_mis");
        chk("lit_addr_mis_set", {31'b0, mismatch}, 32'h1);
        rst_n = 1'b0;
        idle_cycle();
        rst_n = 1'b1;
        issue(rd(32'h0), '{req: 1'b1, we: 1'b0, addr: 32'h0, wdata: '0, be: 4'h3}, 1'b0, "lit_be_mis");
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
